// File: rtl/sseg_edit_ctrl.sv
// Edit/display controller for the 8-digit seven-segment multiplexer.
// Holds a committed 32-bit value and renders it as hex segment patterns.
// A button-driven edit mode changes one digit at a time under a cursor.
// Software can also load the committed value over a valid/ready port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | show the committed value; accept software loads and enter
// ST_EDIT   | show the working copy; cursor, blink gate and timeout active
// ST_COMMIT | one-cycle commit pulse, then return to ST_IDLE
module sseg_edit_ctrl #(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  input  logic        btn_esc,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [31:0] value_out,
  output logic        commit_valid,
  output logic [63:0] sseg_pat,
  output logic [2:0]  active_segment,
  output logic        seg_enable,
  output logic        editing
);

  typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_COMMIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_working, w_working_nxt;
  logic [31:0]   r_committed, w_committed_nxt;
  logic [2:0]    r_cursor, w_cursor_nxt;
  logic [TW-1:0] r_timeout, w_timeout_nxt;

  logic [3:0]    w_nav;
  logic [3:0]    w_nib;
  logic [31:0]   w_disp;
  logic          w_modified;
  logic [63:0]   w_sseg;

  // Active-low segment decode for one hex digit; dp (bit 7) is off.
  function automatic logic [7:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 8'hC0;
      4'h1: f_decode = 8'hF9;
      4'h2: f_decode = 8'hA4;
      4'h3: f_decode = 8'hB0;
      4'h4: f_decode = 8'h99;
      4'h5: f_decode = 8'h92;
      4'h6: f_decode = 8'h82;
      4'h7: f_decode = 8'hF8;
      4'h8: f_decode = 8'h80;
      4'h9: f_decode = 8'h90;
      4'hA: f_decode = 8'h88;
      4'hB: f_decode = 8'h83;
      4'hC: f_decode = 8'hC6;
      4'hD: f_decode = 8'hA1;
      4'hE: f_decode = 8'h86;
      default: f_decode = 8'h8E;
    endcase
  endfunction

  assign w_nav = {btn_left, btn_right, btn_up, btn_down};
  assign w_nib = r_working[{r_cursor, 2'b00} +: 4];

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_working   <= '0;
      r_committed <= '0;
      r_cursor    <= '0;
      r_timeout   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_working   <= w_working_nxt;
      r_committed <= w_committed_nxt;
      r_cursor    <= w_cursor_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Next-state logic; in EDIT only the highest-priority action is taken.
  always_comb begin
    w_state_nxt     = r_state;
    w_working_nxt   = r_working;
    w_committed_nxt = r_committed;
    w_cursor_nxt    = r_cursor;
    w_timeout_nxt   = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          // A load in the same cycle as enter wins; enter is dropped.
          w_committed_nxt = load_data;
          w_working_nxt   = load_data;
        end else if (btn_enter) begin
          w_working_nxt = r_committed;
          w_cursor_nxt  = '0;
          w_timeout_nxt = '0;
          w_state_nxt   = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (btn_esc) begin
          w_working_nxt = r_committed;
          w_state_nxt   = ST_IDLE;
        end else if (btn_enter) begin
          w_committed_nxt = r_working;
          w_state_nxt     = ST_COMMIT;
        end else if ($onehot(w_nav)) begin
          w_timeout_nxt = '0;
          if (btn_left)
            w_cursor_nxt = r_cursor + 3'd1;
          else if (btn_right)
            w_cursor_nxt = r_cursor - 3'd1;
          else if (btn_up)
            w_working_nxt[{r_cursor, 2'b00} +: 4] = w_nib + 4'd1;
          else
            w_working_nxt[{r_cursor, 2'b00} +: 4] = w_nib - 4'd1;
        end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
          // Idle too long: behave exactly like esc.
          w_working_nxt = r_committed;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_timeout_nxt = r_timeout + TW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Display rendering; dp of digit 0 flags an uncommitted edit.
  always_comb begin
    w_sseg     = '0;
    w_disp     = (r_state == ST_EDIT) ? r_working : r_committed;
    w_modified = (r_state == ST_EDIT) && (r_working != r_committed);
    for (int k = 0; k < 8; k++)
      w_sseg[k*8 +: 8] = f_decode(w_disp[k*4 +: 4]);
    if (w_modified)
      w_sseg[7] = 1'b0;
  end

  assign sseg_pat       = w_sseg;
  assign load_ready     = (r_state == ST_IDLE);
  assign value_out      = r_committed;
  assign commit_valid   = (r_state == ST_COMMIT);
  assign editing        = (r_state == ST_EDIT);
  assign seg_enable     = (r_state == ST_EDIT);
  assign active_segment = (r_state == ST_EDIT) ? r_cursor : 3'd0;

endmodule

// File: tb/tb_sseg_edit_ctrl.sv
// Directed bench for sseg_edit_ctrl with a short edit timeout.
module tb_sseg_edit_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic        btn_enter = 1'b0, btn_esc = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic [31:0] value_out;
  logic        commit_valid;
  logic [63:0] sseg_pat;
  logic [2:0]  active_segment;
  logic        seg_enable;
  logic        editing;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulses;

  sseg_edit_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_enter(btn_enter), .btn_esc(btn_esc),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .value_out(value_out), .commit_valid(commit_valid), .sseg_pat(sseg_pat),
    .active_segment(active_segment), .seg_enable(seg_enable), .editing(editing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
    btn_enter = 0; btn_esc = 0; load_valid = 0;
  endtask

  task automatic press(input logic l, r, u, d, en, es);
    btn_left = l; btn_right = r; btn_up = u; btn_down = d;
    btn_enter = en; btn_esc = es;
    step();
    clr();
  endtask

  initial begin
    // reset
    #1 reset_n = 0;
    #2;
    chk("rst_sseg", sseg_pat, 64'hC0C0_C0C0_C0C0_C0C0);
    chk("rst_ready", load_ready, 1);
    chk("rst_value", value_out, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_editing", editing, 0);
    step(); step();
    reset_n = 1;

    // software load
    load_valid = 1; load_data = 32'h1234_ABCD;
    step(); clr();
    chk("load_value", value_out, 32'h1234_ABCD);
    chk("load_sseg", sseg_pat, 64'hF9A4_B099_8883_C6A1);

    // edit: enter, up x3, left, down
    press(0,0,0,0,1,0);
    chk("edit_editing", editing, 1);
    chk("edit_segen", seg_enable, 1);
    chk("edit_ready", load_ready, 0);
    chk("edit_cursor0", active_segment, 0);
    press(0,0,1,0,0,0); press(0,0,1,0,0,0); press(0,0,1,0,0,0);
    chk("edit_up3_sseg", sseg_pat, 64'hF9A4_B099_8883_C640);
    press(1,0,0,0,0,0);
    chk("edit_left_cursor", active_segment, 1);
    press(0,0,0,1,0,0);
    chk("edit_down_sseg", sseg_pat, 64'hF9A4_B099_8883_8340);
    chk("edit_value_held", value_out, 32'h1234_ABCD);
    press(0,0,0,0,1,0);
    chk("commit_pulse", commit_valid, 1);
    chk("commit_value", value_out, 32'h1234_ABB0);
    chk("commit_editing", editing, 0);
    press(0,0,1,0,0,0);   // dropped in COMMIT
    chk("commit_pulse_end", commit_valid, 0);
    chk("commit_segen", seg_enable, 0);
    chk("commit_idle_ready", load_ready, 1);
    chk("commit_sseg", sseg_pat, 64'hF9A4_B099_8883_83C0);

    // cursor wrap
    press(0,0,0,0,1,0);
    press(0,1,0,0,0,0);
    chk("wrap_right", active_segment, 7);
    press(1,0,0,0,0,0);
    chk("wrap_left", active_segment, 0);
    press(0,0,0,0,0,1);
    chk("wrap_esc_editing", editing, 0);
    chk("wrap_esc_value", value_out, 32'h1234_ABB0);

    // nibble wrap from value 0
    load_valid = 1; load_data = 32'h0;
    step(); clr();
    chk("load_zero", value_out, 0);
    press(0,0,0,0,1,0);
    press(0,0,0,1,0,0);
    chk("nib_down_wrap", sseg_pat, 64'hC0C0_C0C0_C0C0_C00E);
    press(0,0,1,0,0,0);
    chk("nib_up_wrap", sseg_pat, 64'hC0C0_C0C0_C0C0_C0C0);

    // esc + enter together aborts
    press(0,0,1,0,0,0);
    press(0,0,0,0,1,1);
    chk("escenter_commit", commit_valid, 0);
    chk("escenter_editing", editing, 0);
    chk("escenter_value", value_out, 0);

    // left + up together ignored
    press(0,0,0,0,1,0);
    press(1,0,1,0,0,0);
    chk("multi_cursor", active_segment, 0);
    chk("multi_sseg", sseg_pat, 64'hC0C0_C0C0_C0C0_C0C0);
    press(0,0,0,0,0,1);

    // load + enter in IDLE: load wins
    load_valid = 1; load_data = 32'hCAFE_0001; btn_enter = 1;
    step(); clr();
    chk("loadenter_value", value_out, 32'hCAFE_0001);
    chk("loadenter_editing", editing, 0);

    // timeout after 16 idle cycles
    press(0,0,0,0,1,0);
    press(0,0,1,0,0,0);
    n_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (commit_valid) n_pulses++;
    end
    chk("to_still_edit", editing, 1);
    step();
    if (commit_valid) n_pulses++;
    chk("to_abort", editing, 0);
    chk("to_value", value_out, 32'hCAFE_0001);
    chk("to_no_commit", n_pulses, 0);
    chk("to_sseg", sseg_pat, 64'hC6_88_8E_86_C0_C0_C0_F9);

    // button at cycle 15 restarts the count
    press(0,0,0,0,1,0);
    for (int i = 0; i < 15; i++) step();
    press(1,0,0,0,0,0);
    for (int i = 0; i < 15; i++) step();
    chk("restart_still_edit", editing, 1);
    chk("restart_cursor", active_segment, 1);
    step();
    chk("restart_abort", editing, 0);

    // async reset mid-edit
    press(0,0,0,0,1,0);
    press(0,0,1,0,0,0);
    chk("pre_rst_sseg", sseg_pat, 64'hC6_88_8E_86_C0_C0_C0_24);
    #2 reset_n = 0;
    #1;
    chk("midrst_value", value_out, 0);
    chk("midrst_segen", seg_enable, 0);
    chk("midrst_commit", commit_valid, 0);
    chk("midrst_editing", editing, 0);
    chk("midrst_sseg", sseg_pat, 64'hC0C0_C0C0_C0C0_C0C0);
    step();
    reset_n = 1;
    step();
    chk("post_rst_ready", load_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
